// File: rtl/lcd_i2c_byte_sequencer.sv
// Wishbone master that drains a small byte FIFO into an I2C master peripheral:
// one-time config/address setup, then data write, start pulse and busy polling per byte.
module lcd_i2c_byte_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3C,
  parameter logic [31:0] CFG_WORD   = 32'h0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          POLL_GAP   = 8,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  byte_data,
  output logic        seq_busy,
  output logic        byte_done,
  output logic        err,
  input  logic        err_clr,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    INIT_CFG, INIT_ADDR, IDLE, WR_DATA, WR_START1, POLL_UP, WR_START0, POLL_DN
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    hold_byte;
  logic          ready_en, push, pop, full;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [PW-1:0] poll_cnt, poll_nxt;
  logic          timed_out, to_nxt, done_nxt, err_set;
  logic          cyc_nxt, we_nxt;
  logic [31:0]   adr_nxt, dat_nxt;
  logic          ack, idle_bus, req, req_we;
  logic [31:0]   req_adr, req_dat;
  logic          unused_dat;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign byte_ready = ready_en & ~full;
  assign push       = byte_valid & byte_ready;
  assign seq_busy   = (count != '0) || (state != IDLE);
  assign wbm_stb_o  = wbm_cyc_o;
  assign wbm_sel_o  = {4{wbm_cyc_o}};
  assign unused_dat = ^wbm_dat_i[31:1];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_byte <= '0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        hold_byte <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT_CFG;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      gap_cnt   <= '0;
      poll_cnt  <= '0;
      timed_out <= 1'b0;
      byte_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      wbm_cyc_o <= cyc_nxt;
      wbm_we_o  <= we_nxt;
      wbm_adr_o <= adr_nxt;
      wbm_dat_o <= dat_nxt;
      gap_cnt   <= gap_nxt;
      poll_cnt  <= poll_nxt;
      timed_out <= to_nxt;
      byte_done <= done_nxt;
      err       <= (err & ~err_clr) | err_set;
    end
  end

  // Each bus state requests one cycle while the bus is idle and advances on its ack.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = wbm_cyc_o;
    we_nxt    = wbm_we_o;
    adr_nxt   = wbm_adr_o;
    dat_nxt   = wbm_dat_o;
    gap_nxt   = gap_cnt;
    poll_nxt  = poll_cnt;
    to_nxt    = timed_out;
    done_nxt  = 1'b0;
    err_set   = 1'b0;
    pop       = 1'b0;
    req       = 1'b0;
    req_we    = 1'b0;
    req_adr   = 32'h0;
    req_dat   = 32'h0;
    ack       = wbm_cyc_o & wbm_ack_i;
    idle_bus  = ~wbm_cyc_o;

    if (ack) begin
      cyc_nxt = 1'b0;
      we_nxt  = 1'b0;
      adr_nxt = '0;
      dat_nxt = '0;
      gap_nxt = GW'(POLL_GAP - 1);
    end else if (idle_bus && gap_cnt != '0) begin
      gap_nxt = gap_cnt - GW'(1);
    end

    case (state)
      INIT_CFG: begin
        if (ack) state_nxt = INIT_ADDR;
        else begin
          req = idle_bus; req_we = 1'b1; req_adr = 32'h08; req_dat = CFG_WORD;
        end
      end
      INIT_ADDR: begin
        if (ack) state_nxt = IDLE;
        else begin
          req = idle_bus; req_we = 1'b1; req_adr = 32'h0C; req_dat = {25'b0, SLAVE_ADDR};
        end
      end
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (ack) state_nxt = WR_START1;
        else begin
          req = idle_bus; req_we = 1'b1; req_adr = 32'h10; req_dat = {24'b0, hold_byte};
        end
      end
      WR_START1: begin
        if (ack) begin
          state_nxt = POLL_UP;
          poll_nxt  = '0;
          to_nxt    = 1'b0;
        end else begin
          req = idle_bus; req_we = 1'b1; req_adr = 32'h14; req_dat = 32'h1;
        end
      end
      POLL_UP: begin
        // A read returning busy wins even when it is the last allowed read.
        if (ack) begin
          if (wbm_dat_i[0]) state_nxt = WR_START0;
          else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
            err_set   = 1'b1;
            to_nxt    = 1'b1;
            state_nxt = WR_START0;
          end else poll_nxt = poll_cnt + PW'(1);
        end else begin
          req = idle_bus && (gap_cnt == '0); req_adr = 32'h00;
        end
      end
      WR_START0: begin
        if (ack) state_nxt = timed_out ? IDLE : POLL_DN;
        else begin
          req = idle_bus; req_we = 1'b1; req_adr = 32'h14; req_dat = 32'h0;
        end
      end
      POLL_DN: begin
        if (ack) begin
          if (!wbm_dat_i[0]) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          req = idle_bus && (gap_cnt == '0); req_adr = 32'h00;
        end
      end
      default: state_nxt = INIT_CFG;
    endcase

    if (req) begin
      cyc_nxt = 1'b1;
      we_nxt  = req_we;
      adr_nxt = req_adr;
      dat_nxt = req_dat;
    end
  end
endmodule

// File: tb/tb_lcd_i2c_byte_sequencer.sv
// Self-checking bench for lcd_i2c_byte_sequencer: a Wishbone slave model acking one
// cycle after stb, scripted busy responses, a table of single-byte vectors and corner sequences.
module tb_lcd_i2c_byte_sequencer;
  localparam int LIMIT = 4;
  localparam int GAP   = 2;
  localparam int BOUND = 3000;

  typedef struct {
    int up_at;
    int dn_at;
    bit clr_at_to;
  } mode_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          start;
  } txn_t;

  typedef struct {
    logic [7:0] data;
    int         up_at;
    int         dn_at;
    int         exp_reads;
    int         exp_done;
    logic       exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h0;
  logic        err_clr_main = 1'b0;
  logic        err_clr_model;
  logic        err_clr;
  logic        byte_ready, seq_busy, byte_done, err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  int    compared = 0;
  int    mismatched = 0;
  int    cyc_no = 0;
  int    done_cnt = 0;
  int    sel_bad = 0;
  int    pushes = 0;
  int    stall_at = -1;
  bit    in_dn = 1'b0;
  txn_t  log_q[$];
  mode_t mode_q[$];
  vec_t  vecs[4];

  assign err_clr = err_clr_main | err_clr_model;

  lcd_i2c_byte_sequencer #(
    .SLAVE_ADDR(7'h3C), .CFG_WORD(32'h0), .FIFO_DEPTH(4), .POLL_GAP(GAP), .POLL_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .seq_busy(seq_busy), .byte_done(byte_done), .err(err), .err_clr(err_clr),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  initial forever begin
    @(negedge clk);
    if (byte_done) done_cnt++;
  end

  // Slave model: ack raised in the cycle after stb; status reads follow the current byte's busy script.
  initial begin
    int    age;
    int    rd_n;
    int    start_cyc;
    logic  busy;
    logic [31:0] resp;
    mode_t cur;
    age = 0; rd_n = 0; start_cyc = 0;
    cur = '{1, 2, 1'b0};
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0; err_clr_model = 1'b0;
    forever begin
      @(negedge clk);
      err_clr_model = 1'b0;
      if (reset) begin
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0; age = 0;
      end else if (wbm_ack_i) begin
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0; age = 0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        age++;
        if (age == 1) start_cyc = cyc_no;
        if (age == 2) begin
          resp = 32'h0;
          if (wbm_we_o) begin
            if (wbm_adr_o == 32'h14 && wbm_dat_o == 32'h1) begin
              cur = (mode_q.size() > 0) ? mode_q.pop_front() : '{1, 2, 1'b0};
              rd_n = 0; in_dn = 1'b0;
            end
            if (wbm_adr_o == 32'h14 && wbm_dat_o == 32'h0) in_dn = 1'b1;
          end else begin
            rd_n++;
            busy = (rd_n >= cur.up_at) && (rd_n < cur.dn_at);
            resp = {31'b0, busy};
            if (cur.clr_at_to && rd_n == LIMIT && !busy) err_clr_model = 1'b1;
          end
          if (wbm_sel_o != 4'hF) sel_bad++;
          log_q.push_back('{wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : resp, start_cyc});
          wbm_dat_i = resp;
          wbm_ack_i = 1'b1;
        end
      end else age = 0;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Offers one byte starting at a negedge; returns at the negedge after it was accepted.
  task automatic applyStimulus(input logic [7:0] d, input int up_at, input int dn_at, input bit clr);
    int n = 0;
    mode_q.push_back('{up_at, dn_at, clr});
    byte_valid = 1'b1;
    byte_data  = d;
    while (!byte_ready && n < BOUND) begin
      if (stall_at < 0) stall_at = pushes;
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      compared++; mismatched++;
      $display("[TB] FAIL push %0h: byte_ready stayed 0 for %0d cycles, required 1", d, n);
    end
    @(negedge clk);
    pushes++;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge clk);
    while (seq_busy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (n >= BOUND) begin
      compared++; mismatched++;
      $display("[TB] FAIL %s idle: seq_busy still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic checkInit(input string name);
    checkOutput({name, " first stb"}, 32'(wbm_stb_o), 32'h1);
    checkOutput({name, " first adr"}, wbm_adr_o, 32'h08);
    checkOutput({name, " ready after edge"}, 32'(byte_ready), 32'h1);
    waitIdle(name);
    checkOutput({name, " txn count"}, log_q.size(), 32'd2);
    if (log_q.size() >= 2) begin
      checkOutput({name, " cfg adr"}, log_q[0].adr, 32'h08);
      checkOutput({name, " cfg dat"}, log_q[0].dat, 32'h0);
      checkOutput({name, " addr adr"}, log_q[1].adr, 32'h0C);
      checkOutput({name, " addr dat"}, log_q[1].dat, 32'h3C);
      checkOutput({name, " both writes"}, 32'({log_q[0].we, log_q[1].we}), 32'h3);
    end
    checkOutput({name, " seq_busy"}, 32'(seq_busy), 32'h0);
  endtask

  task automatic collectData(output int nd, output logic [7:0] got[8]);
    nd = 0;
    foreach (got[k]) got[k] = 8'h0;
    foreach (log_q[j]) begin
      if (log_q[j].we && log_q[j].adr == 32'h10) begin
        if (nd < 8) got[nd] = log_q[j].dat[7:0];
        nd++;
      end
    end
  endtask

  initial begin
    int         nw, nr, rd_bad, d0, nd, n;
    logic [31:0] wa[3];
    logic [31:0] wd[3];
    logic [7:0]  got[8];
    logic [7:0]  six[6];

    vecs[0] = '{8'hAC, 2, 5, 5, 1, 1'b0};
    vecs[1] = '{8'h55, 1, 2, 2, 1, 1'b0};
    vecs[2] = '{8'h0F, 1000, 1000, LIMIT, 0, 1'b1};
    vecs[3] = '{8'hF0, LIMIT, LIMIT + 1, LIMIT + 1, 1, 1'b1};
    six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset state and init programming.
    @(negedge clk);
    checkOutput("reset cyc", 32'(wbm_cyc_o), 32'h0);
    checkOutput("reset ready", 32'(byte_ready), 32'h0);
    checkOutput("reset seq_busy", 32'(seq_busy), 32'h1);
    checkOutput("reset err/done", 32'({err, byte_done}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkInit("init");

    // Table of single bytes with different busy scripts.
    for (int i = 0; i < 4; i++) begin
      log_q.delete();
      d0 = done_cnt;
      applyStimulus(vecs[i].data, vecs[i].up_at, vecs[i].dn_at, 1'b0);
      byte_valid = 1'b0;
      waitIdle($sformatf("v%0d", i));
      nw = 0; nr = 0; rd_bad = 0;
      foreach (wa[k]) begin wa[k] = '0; wd[k] = '0; end
      foreach (log_q[j]) begin
        if (log_q[j].we) begin
          if (nw < 3) begin wa[nw] = log_q[j].adr; wd[nw] = log_q[j].dat; end
          nw++;
        end else begin
          nr++;
          if (log_q[j].adr != 32'h0) rd_bad++;
        end
      end
      checkOutput($sformatf("v%0d writes", i), nw, 32'd3);
      checkOutput($sformatf("v%0d data adr", i), wa[0], 32'h10);
      checkOutput($sformatf("v%0d data dat", i), wd[0], {24'b0, vecs[i].data});
      checkOutput($sformatf("v%0d start1", i), {wa[1][7:0], wd[1][23:0]}, 32'h14000001);
      checkOutput($sformatf("v%0d start0", i), {wa[2][7:0], wd[2][23:0]}, 32'h14000000);
      checkOutput($sformatf("v%0d reads", i), nr, vecs[i].exp_reads);
      checkOutput($sformatf("v%0d read adr", i), rd_bad, 32'd0);
      checkOutput($sformatf("v%0d done", i), done_cnt - d0, vecs[i].exp_done);
      checkOutput($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      if (i == 0 && log_q.size() >= 2)
        checkOutput("v0 start1 spacing", log_q[1].start - log_q[0].start, 32'd3);
    end

    // err_clr alone clears on the next cycle.
    err_clr_main = 1'b1;
    @(negedge clk);
    err_clr_main = 1'b0;
    checkOutput("err_clr alone", 32'(err), 32'h0);

    // Timeout coinciding with err_clr, followed by a normal byte.
    log_q.delete();
    d0 = done_cnt;
    applyStimulus(8'h3C, 1000, 1000, 1'b1);
    applyStimulus(8'h77, 1, 2, 1'b0);
    byte_valid = 1'b0;
    waitIdle("timeout+clr");
    checkOutput("set beats clr", 32'(err), 32'h1);
    checkOutput("timeout done", done_cnt - d0, 32'd1);
    collectData(nd, got);
    checkOutput("timeout data count", nd, 32'd2);
    checkOutput("timeout data order", {got[0], got[1]}, 32'h3C77);

    // Six bytes back to back against a 4-deep FIFO.
    log_q.delete();
    d0 = done_cnt;
    pushes = 0;
    stall_at = -1;
    for (int i = 0; i < 6; i++) applyStimulus(six[i], 1, 2, 1'b0);
    byte_valid = 1'b0;
    waitIdle("six");
    checkOutput("six stall point", stall_at, 32'd5);
    checkOutput("six done", done_cnt - d0, 32'd6);
    collectData(nd, got);
    checkOutput("six data count", nd, 32'd6);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("six data %0d", i), got[i], six[i]);

    // Reset while a POLL_DN read is on the bus, with a byte still queued.
    applyStimulus(8'h99, 1, 1000, 1'b0);
    applyStimulus(8'h42, 1, 2, 1'b0);
    byte_valid = 1'b0;
    n = 0;
    while (!(in_dn && wbm_cyc_o && !wbm_we_o) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      compared++; mismatched++;
      $display("[TB] FAIL poll_dn wait: no POLL_DN read after %0d cycles, required one", n);
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset cyc/stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'h0);
    checkOutput("midreset ready", 32'(byte_ready), 32'h0);
    checkOutput("midreset seq_busy", 32'(seq_busy), 32'h1);
    repeat (2) @(negedge clk);
    log_q.delete();
    mode_q.delete();
    in_dn = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkInit("reinit");
    repeat (20) @(negedge clk);
    checkOutput("reinit fifo empty", log_q.size(), 32'd2);

    checkOutput("sel during cycles", sel_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
